// File: rtl/dibu_loader.sv
// Byte-stream program loader: receives a length byte and then that many 16-bit words
// (high byte first), writes them to code memory, and then enables the datapath.
`timescale 1ns/1ps

module dibu_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              code_w_en,
   output logic [ADDR_W-1:0] code_addr_in,
   output logic [15:0]       code_in,
   output logic              run,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, RUN} state_t;

   state_t            state, nxt;
   logic [7:0]        count;
   logic [7:0]        high;
   logic [ADDR_W-1:0] addr;
   logic              accept;

   assign accept = rx_valid && rx_ready;

   // load_req outranks a byte handshake, so any partial data is dropped on a restart.
   always_comb begin
      // NOTE: the default assignment gives every path a value, so no latch is inferred.
      nxt = state;
      unique case (state)
         IDLE: if (load_req) nxt = LEN;
         LEN:  if (load_req) nxt = LEN;
               else if (accept) nxt = (rx_data == 8'd0) ? RUN : HI;
         HI:   if (load_req) nxt = LEN;
               else if (accept) nxt = LO;
         LO:   if (load_req) nxt = LEN;
               else if (accept) nxt = WR;
         WR:   if (load_req) nxt = LEN;
               else if (count == 8'd1) nxt = RUN;
               else nxt = HI;
         RUN:  if (load_req) nxt = LEN;
         default: nxt = IDLE;
      endcase
   end

   // Port flags are registered from the next state, so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every register is cleared, including the datapath ones, because the
         // reset values of code_addr_in and code_in are visible at the ports.
         state        <= IDLE;
         rx_ready     <= 1'b0;
         busy         <= 1'b0;
         run          <= 1'b0;
         code_w_en    <= 1'b0;
         code_addr_in <= '0;
         code_in      <= '0;
         count        <= '0;
         high         <= '0;
         addr         <= '0;
      end else begin
         state     <= nxt;
         rx_ready  <= (nxt == LEN) || (nxt == HI) || (nxt == LO);
         busy      <= (nxt == LEN) || (nxt == HI) || (nxt == LO) || (nxt == WR);
         run       <= (nxt == RUN);
         code_w_en <= (nxt == WR);

         if (state == LEN && !load_req && accept) begin
            count <= rx_data;
            if (rx_data != 8'd0) addr <= '0;
         end
         if (state == HI && !load_req && accept) high <= rx_data;
         // Write address and data change only when WR is entered and hold everywhere else.
         if (state == LO && !load_req && accept) begin
            code_in      <= {high, rx_data};
            code_addr_in <= addr;
         end
         if (state == WR) begin
            addr  <= addr + ADDR_W'(1);
            count <= count - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_dibu_loader.sv
// Randomized bench for dibu_loader: programs are turned into an expected write list
// and checked against the observed write strobes, with timing checks in the driver.
`timescale 1ns/1ps

module tb_dibu_loader;

   localparam int AW = 3;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_req;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          code_w_en;
   logic [AW-1:0] code_addr_in;
   logic [15:0]   code_in;
   logic          run;
   logic          busy;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   logic [15:0] prog[$];
   wr_t         mon_e;
   bit          mon_en = 1'b0;
   bit          wr_pending = 1'b0;

   always #5 clk = ~clk;

   dibu_loader #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_req     (load_req),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .code_w_en    (code_w_en),
      .code_addr_in (code_addr_in),
      .code_in      (code_in),
      .run          (run),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: each strobe consumes the oldest expected write; a strobe with none pending is spurious.
   always @(negedge clk) begin
      if (mon_en) begin
         if (code_w_en) begin
            if (exp_q.size() == 0) begin
               check("spurious_wr", {31'd0, code_w_en}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", {29'd0, code_addr_in}, {29'd0, mon_e.addr});
               check("wr_data", {16'd0, code_in}, {16'd0, mon_e.data});
            end
         end
         if (run) check("run_ports", {29'd0, busy, rx_ready, code_w_en}, 32'd0);
      end
   end

   // Runs in the write cycle that follows a low-byte handshake.
   task automatic do_pending();
      if (wr_pending) begin
         check("wr_strobe", {31'd0, code_w_en}, 32'd1);
         check("wr_no_ready", {31'd0, rx_ready}, 32'd0);
         check("wr_busy", {31'd0, busy}, 32'd1);
         wr_pending = 1'b0;
      end
   endtask

   // Starts and ends just after a rising edge; gap idle cycles precede the byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      rx_valid = 1'b0;
      for (int k = 0; k < gap; k++) begin
         @(negedge clk); do_pending();
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk); do_pending();
         if (rx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("hs_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic start_load();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      @(negedge clk);
      check("len_busy", {31'd0, busy}, 32'd1);
      check("len_ready", {31'd0, rx_ready}, 32'd1);
      check("len_run", {31'd0, run}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Loads prog[0..n-1]; reload_at >= 0 raises load_req in that word's write cycle.
   task automatic run_program(input int n, input int gap_max, input int reload_at);
      wr_t pe;
      start_load();
      send_byte(8'(n), $urandom_range(gap_max, 0));
      if (n == 0) begin
         @(negedge clk);
         check("empty_run", {31'd0, run}, 32'd1);
         check("empty_no_wr", {31'd0, code_w_en}, 32'd0);
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         send_byte(prog[i][15:8], $urandom_range(gap_max, 0));
         send_byte(prog[i][7:0], $urandom_range(gap_max, 0));
         pe.addr = AW'(i % (1 << AW));
         pe.data = prog[i];
         exp_q.push_back(pe);
         wr_pending = 1'b1;
         if (i == reload_at) begin
            load_req = 1'b1;
            @(negedge clk); do_pending();
            @(posedge clk); #1;
            load_req = 1'b0;
            @(negedge clk);
            check("reload_wr_len", {30'd0, busy, rx_ready}, 32'd3);
            @(posedge clk); #1;
            return;
         end
      end
      @(negedge clk); do_pending();
      @(negedge clk);
      check("run_after_wr", {31'd0, run}, 32'd1);
      check("busy_after_wr", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      int ra;
      rst      = 1'b1;
      load_req = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_flags", {28'd0, rx_ready, busy, run, code_w_en}, 32'd0);
      check("rst_addr", {29'd0, code_addr_in}, 32'd0);
      check("rst_code", {16'd0, code_in}, 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("idle_flags", {29'd0, run, busy, rx_ready}, 32'd0);
         @(posedge clk); #1;
      end

      // Basic two-word load; the second high byte is offered during the first write.
      prog = '{16'h1234, 16'hABCD};
      run_program(2, 0, -1);

      prog = '{};
      run_program(0, 0, -1);

      // Bytes offered in RUN must be refused.
      rx_valid = 1'b1;
      rx_data  = 8'h99;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("run_ignores_rx", {30'd0, run, rx_ready}, 32'd2);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;

      prog = '{16'hA1B2, 16'h12C3};
      run_program(2, 0, -1);

      prog = '{16'h0007};
      run_program(1, 0, -1);

      // Restart while in LO drops the partial word.
      start_load();
      send_byte(8'd3, 0);
      send_byte(8'hEE, 0);
      prog = '{16'hBEEF};
      run_program(1, 1, -1);

      // Reload during a write: that write completes, then a fresh load follows.
      prog = '{16'h1111, 16'h2222, 16'h3333};
      run_program(3, 0, 1);
      prog = '{16'h4444};
      run_program(1, 0, -1);

      // Address wraps modulo 2^AW.
      prog = '{};
      for (int i = 0; i < 10; i++) prog.push_back(16'($urandom));
      run_program(10, 1, -1);

      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(12, 0);
         prog = '{};
         for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
         ra = (n > 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
         run_program(n, $urandom_range(2, 0), ra);
      end

      // Reset one cycle after the high byte, while load_req and a byte are also present.
      start_load();
      send_byte(8'd2, 0);
      send_byte(8'h55, 0);
      rst      = 1'b1;
      load_req = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h66;
      @(posedge clk); #1;
      rst      = 1'b0;
      load_req = 1'b0;
      rx_valid = 1'b0;
      check("abort_flags", {28'd0, rx_ready, busy, run, code_w_en}, 32'd0);
      check("abort_addr", {29'd0, code_addr_in}, 32'd0);
      check("abort_code", {16'd0, code_in}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("abort_idle", {29'd0, run, busy, code_w_en}, 32'd0);
         @(posedge clk); #1;
      end

      check("exp_q_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dibu_loader.md
DIBU_LOADER -- requirements
Module: dibu_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the code-memory address.
REQ-002 Instruction width SHALL be fixed at 16 bits, assembled from two bytes.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_req  input  1  start a new program load; level sampled each cycle.
REQ-006 rx_data  input  8  incoming byte stream.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-009 code_w_en  output  1  code-memory write strobe to the datapath.
REQ-010 code_addr_in  output  ADDR_W  code-memory write address.
REQ-011 code_in  output  16  code-memory write data.
REQ-012 run  output  1  datapath run enable.
REQ-013 busy  output  1  load in progress.

Function
REQ-014 FSM states SHALL be IDLE, LEN, HI, LO, WR, RUN; all outputs SHALL be registered or decoded from state only (Moore).
REQ-015 IDLE: rx_ready=0, busy=0, run=0; load_req=1 moves the FSM to LEN.
REQ-016 LEN: rx_ready=1, busy=1; an accepted byte is stored as count N (8-bit).
REQ-017 On acceptance in LEN, N=0 SHALL go to RUN with no write; N>0 SHALL clear the address to 0 and go to HI.
REQ-018 HI: rx_ready=1; the accepted byte SHALL latch as the high byte, then the FSM moves to LO.
REQ-019 LO: rx_ready=1; the accepted byte SHALL set code_in={high,byte}, then the FSM moves to WR.
REQ-020 WR: exactly one cycle with code_w_en=1, rx_ready=0, and code_addr_in equal to the current address.
REQ-021 WR exit: address increments by 1 and remaining count decrements by 1; remaining reaching 0 goes to RUN, otherwise HI.
REQ-022 Latency: code_w_en SHALL rise on the cycle after the LO handshake, and run SHALL rise on the cycle after the last WR.
REQ-023 RUN: run=1, busy=0, rx_ready=0; bytes presented in RUN SHALL be ignored and not consumed.
REQ-024 load_req in RUN SHALL go to LEN; run=0 from the next cycle.
REQ-025 load_req in LEN, HI or LO SHALL restart at LEN and discard partial data, with no write issued.
REQ-026 load_req in WR: the WR write still completes that cycle, then the FSM goes to LEN.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; N > 2^ADDR_W wraps and overwrites from address 0.
REQ-028 code_w_en SHALL never be high outside WR; code_addr_in and code_in SHALL hold their values when not in WR.
REQ-029 Stalls (rx_valid=0) in LEN, HI or LO SHALL hold state indefinitely with no timeout.

Reset
REQ-030 rst=1 SHALL force IDLE, run=0, busy=0, rx_ready=0, code_w_en=0, code_addr_in=0, code_in=0, count=0 on the next edge.
REQ-031 rst SHALL take priority over load_req and rx handshakes in the same cycle.
REQ-032 rst mid-load SHALL abandon the load without any further write; memory contents already written are left untouched.
REQ-033 After reset the block SHALL remain in IDLE with run=0 until load_req.

Verification
REQ-034 Reset: assert rst 2 cycles -> all outputs 0, rx_ready=0; run stays 0 for 10 idle cycles.
REQ-035 Load: load_req, then bytes 02,12,34,AB,CD -> writes (addr 0, 0x1234) and (addr 1, 0xABCD), each exactly 1 cycle; run=1 one cycle after the second write.
REQ-036 Empty load: load_req, then byte 00 -> run=1 with no code_w_en pulse.
REQ-037 Backpressure: rx_valid held high with 12 presented during WR -> rx_ready=0 in WR; 12 accepted in the following HI cycle, not lost or duplicated.
REQ-038 Reload: load_req while run=1 -> run=0 next cycle; bytes 01,00,07 -> write (0, 0x0007), then run=1.
REQ-039 Abort: rst one cycle after the HI byte 55 is accepted -> IDLE, no code_w_en, run=0.
